armleocpu_decode: RTL and testbench

- Decode stage; the receiving end of the fetch→decode interface (f2d_*) and the source of the decode→fetch command path (d2f_*).
- Holds a one-entry pipeline register between fetch and execute, extracts register addresses and opcode class, and flags illegal encodings.
- Forwards execute's redirect commands to fetch and kills in-flight work on redirect.
- Tracks trap entries (fetch exception or interrupt) until execute issues the bubble jump that releases fetch.

---
 rtl/armleocpu_decode_pkg.sv | 40 ++++
 rtl/armleocpu_decode_if.sv | 57 +++++
 rtl/armleocpu_decode_imm.sv | 31 +++
 rtl/armleocpu_decode.sv | 131 +++++++++++++
 tb/tb_armleocpu_decode.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/armleocpu_decode_pkg.sv
// armleocpu_decode_pkg: shared command encodings and RV32 major-opcode
// constants for the decode stage and its neighbours.
// Optional build macro used by this slice: ARMLEOCPU_DECODE_IMM_EN.
package armleocpu_decode_pkg;

    localparam int E2F_CMD_WIDTH = 2;

    typedef enum logic [E2F_CMD_WIDTH-1:0] {
        E2F_CMD_NONE        = 2'd0,
        E2F_CMD_BRANCHTAKEN = 2'd1,
        E2F_CMD_FLUSH       = 2'd2,
        E2F_CMD_BUBBLE_JUMP = 2'd3
    } e2f_cmd_t;

    localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
    localparam logic [4:0] OPCODE_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPCODE_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
    localparam logic [4:0] OPCODE_STORE    = 5'b01000;
    localparam logic [4:0] OPCODE_OP       = 5'b01100;
    localparam logic [4:0] OPCODE_LUI      = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
    localparam logic [4:0] OPCODE_JALR     = 5'b11001;
    localparam logic [4:0] OPCODE_JAL      = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM   = 5'b11100;

    // Major opcodes that the core implements; everything else is illegal.
    function automatic logic is_supported_opcode(input logic [4:0] opcode);
        logic supported;
        supported = 1'b0;
        case (opcode)
            OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC,
            OPCODE_STORE, OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH,
            OPCODE_JALR, OPCODE_JAL, OPCODE_SYSTEM: supported = 1'b1;
            default: supported = 1'b0;
        endcase
        return supported;
    endfunction

endpackage

// File: rtl/armleocpu_decode_if.sv
// armleocpu_decode_if: fetch->decode, decode->fetch, decode->execute and
// execute->decode signal bundle. The slave modport is the decode stage,
// the master modport is the surrounding pipeline (fetch + execute).
interface armleocpu_decode_if;
    import armleocpu_decode_pkg::*;

    logic        f2d_instr_valid;
    logic [31:0] f2d_instr;
    logic [31:0] f2d_pc;
    logic        f2d_instr_fetch_exception;
    logic [31:0] f2d_instr_fetch_exception_cause;
    logic        f2d_interrupt_pending;

    logic        d2f_ready;
    e2f_cmd_t    d2f_cmd;
    logic [31:0] d2f_jump_target;

    logic        d2e_instr_valid;
    logic [31:0] d2e_instr;
    logic [31:0] d2e_pc;
    logic [4:0]  d2e_rd_addr;
    logic [4:0]  d2e_rs1_addr;
    logic [4:0]  d2e_rs2_addr;
    logic [4:0]  d2e_opcode;
    logic        d2e_illegal_instr;
    logic        d2e_instr_fetch_exception;
    logic [31:0] d2e_instr_fetch_exception_cause;
    logic        d2e_interrupt_pending;
    logic [31:0] d2e_imm;

    logic        e2d_ready;
    e2f_cmd_t    e2d_cmd;
    logic [31:0] e2d_jump_target;

    modport slave (
        input  f2d_instr_valid, f2d_instr, f2d_pc, f2d_instr_fetch_exception,
               f2d_instr_fetch_exception_cause, f2d_interrupt_pending,
               e2d_ready, e2d_cmd, e2d_jump_target,
        output d2f_ready, d2f_cmd, d2f_jump_target,
               d2e_instr_valid, d2e_instr, d2e_pc, d2e_rd_addr, d2e_rs1_addr,
               d2e_rs2_addr, d2e_opcode, d2e_illegal_instr,
               d2e_instr_fetch_exception, d2e_instr_fetch_exception_cause,
               d2e_interrupt_pending, d2e_imm
    );

    modport master (
        output f2d_instr_valid, f2d_instr, f2d_pc, f2d_instr_fetch_exception,
               f2d_instr_fetch_exception_cause, f2d_interrupt_pending,
               e2d_ready, e2d_cmd, e2d_jump_target,
        input  d2f_ready, d2f_cmd, d2f_jump_target,
               d2e_instr_valid, d2e_instr, d2e_pc, d2e_rd_addr, d2e_rs1_addr,
               d2e_rs2_addr, d2e_opcode, d2e_illegal_instr,
               d2e_instr_fetch_exception, d2e_instr_fetch_exception_cause,
               d2e_interrupt_pending, d2e_imm
    );

endinterface

// File: rtl/armleocpu_decode_imm.sv
// armleocpu_decode_imm: combinational RV32 immediate extractor, selected by
// the major opcode. Only built when ARMLEOCPU_DECODE_IMM_EN is defined.
`ifdef ARMLEOCPU_DECODE_IMM_EN
module armleocpu_decode_imm
    import armleocpu_decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Pick the I/S/B/U/J format from the opcode, sign-extended from bit 31.
    always_comb begin
        imm = 32'd0;
        case (instr[6:2])
            OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR, OPCODE_SYSTEM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPCODE_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPCODE_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPCODE_LUI, OPCODE_AUIPC:
                imm = {instr[31:12], 12'd0};
            OPCODE_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule
`endif

// File: rtl/armleocpu_decode.sv
// armleocpu_decode: one-entry pipeline register between fetch and execute.
// Extracts register fields and opcode, flags illegal encodings, forwards
// execute's redirects to fetch and holds fetch off after a trap entry until
// execute's bubble jump releases it.
// Optional build macro: ARMLEOCPU_DECODE_IMM_EN (registered immediate on d2e_imm).
module armleocpu_decode
    import armleocpu_decode_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    armleocpu_decode_if.slave bus
);

    logic        valid_q,     valid_d;
    logic        trap_wait_q, trap_wait_d;
    logic [31:0] instr_q,     instr_d;
    logic [31:0] pc_q,        pc_d;
    logic        exc_q,       exc_d;
    logic [31:0] cause_q,     cause_d;
    logic        irq_q,       irq_d;
    logic        illegal_q,   illegal_d;

    logic f2d_entry;
    logic consume;
    logic ready;
    logic trap_entry;

`ifdef ARMLEOCPU_DECODE_IMM_EN
    logic [31:0] imm_q, imm_d, imm_next;

    armleocpu_decode_imm u_imm (
        .instr (bus.f2d_instr),
        .imm   (imm_next)
    );
`endif

    // Handshake terms, then the prioritised next-state of the entry register.
    always_comb begin
        f2d_entry  = bus.f2d_instr_valid | bus.f2d_instr_fetch_exception | bus.f2d_interrupt_pending;
        trap_entry = bus.f2d_instr_fetch_exception | bus.f2d_interrupt_pending;
        consume    = valid_q & bus.e2d_ready;
        ready      = !trap_wait_q & (!valid_q | bus.e2d_ready);

        valid_d     = valid_q;
        trap_wait_d = trap_wait_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        exc_d       = exc_q;
        cause_d     = cause_q;
        irq_d       = irq_q;
        illegal_d   = illegal_q;
`ifdef ARMLEOCPU_DECODE_IMM_EN
        imm_d       = imm_q;
`endif

        if (consume && (bus.e2d_cmd != E2F_CMD_NONE)) begin
            // Redirect kills the held entry and anything fetch offers now.
            valid_d = 1'b0;
            if (bus.e2d_cmd == E2F_CMD_BUBBLE_JUMP) begin
                trap_wait_d = 1'b0;
            end
        end else if (ready && f2d_entry) begin
            valid_d     = 1'b1;
            trap_wait_d = trap_entry;
            instr_d     = bus.f2d_instr;
            pc_d        = bus.f2d_pc;
            exc_d       = bus.f2d_instr_fetch_exception;
            cause_d     = bus.f2d_instr_fetch_exception_cause;
            irq_d       = bus.f2d_interrupt_pending;
            illegal_d   = !trap_entry &
                          ((bus.f2d_instr[1:0] != 2'b11) | !is_supported_opcode(bus.f2d_instr[6:2]));
`ifdef ARMLEOCPU_DECODE_IMM_EN
            imm_d       = imm_next;
`endif
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    // Entry register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            trap_wait_q <= 1'b0;
            instr_q     <= 32'd0;
            pc_q        <= 32'd0;
            exc_q       <= 1'b0;
            cause_q     <= 32'd0;
            irq_q       <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ARMLEOCPU_DECODE_IMM_EN
            imm_q       <= 32'd0;
`endif
        end else begin
            valid_q     <= valid_d;
            trap_wait_q <= trap_wait_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            exc_q       <= exc_d;
            cause_q     <= cause_d;
            irq_q       <= irq_d;
            illegal_q   <= illegal_d;
`ifdef ARMLEOCPU_DECODE_IMM_EN
            imm_q       <= imm_d;
`endif
        end
    end

    assign bus.d2f_ready       = ready;
    assign bus.d2f_cmd         = consume ? bus.e2d_cmd : E2F_CMD_NONE;
    assign bus.d2f_jump_target = bus.e2d_jump_target;

    assign bus.d2e_instr_valid                 = valid_q;
    assign bus.d2e_instr                       = instr_q;
    assign bus.d2e_pc                          = pc_q;
    assign bus.d2e_rd_addr                     = instr_q[11:7];
    assign bus.d2e_rs1_addr                    = instr_q[19:15];
    assign bus.d2e_rs2_addr                    = instr_q[24:20];
    assign bus.d2e_opcode                      = instr_q[6:2];
    assign bus.d2e_illegal_instr               = illegal_q;
    assign bus.d2e_instr_fetch_exception       = exc_q;
    assign bus.d2e_instr_fetch_exception_cause = cause_q;
    assign bus.d2e_interrupt_pending           = irq_q;

`ifdef ARMLEOCPU_DECODE_IMM_EN
    assign bus.d2e_imm = imm_q;
`else
    assign bus.d2e_imm = 32'd0;
`endif

endmodule

// File: tb/tb_armleocpu_decode.sv
// tb_armleocpu_decode: table-driven directed bench for armleocpu_decode.
// Each table row is one clock: inputs, expected combinational outputs in
// that cycle, and expected registered outputs after the edge.
module tb_armleocpu_decode;
    import armleocpu_decode_pkg::*;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;

    armleocpu_decode_if bus ();

    armleocpu_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        fv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
        logic [31:0] cause;
        logic        irq;
        logic        er;
        e2f_cmd_t    ecmd;
        logic [31:0] jt;
        logic        xReady;
        e2f_cmd_t    xCmd;
        logic        xValid;
        logic [31:0] xInstr;
        logic [31:0] xPc;
        logic        xIllegal;
        logic        xExc;
        logic [31:0] xCause;
        logic        xIrq;
        logic [31:0] xImm;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic applyStimulus(input vec_t v);
        rst_n                               = v.rst_n;
        bus.f2d_instr_valid                 = v.fv;
        bus.f2d_instr                       = v.instr;
        bus.f2d_pc                          = v.pc;
        bus.f2d_instr_fetch_exception       = v.exc;
        bus.f2d_instr_fetch_exception_cause = v.cause;
        bus.f2d_interrupt_pending           = v.irq;
        bus.e2d_ready                       = v.er;
        bus.e2d_cmd                         = v.ecmd;
        bus.e2d_jump_target                 = v.jt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Registered-output comparisons against one table row's expectations.
    task automatic checkRegistered(input string tag, input vec_t v);
        logic [31:0] expImm;
`ifdef ARMLEOCPU_DECODE_IMM_EN
        expImm = v.xImm;
`else
        expImm = 32'd0;
`endif
        checkOutput({tag, " valid"},   32'(bus.d2e_instr_valid), 32'(v.xValid));
        checkOutput({tag, " instr"},   bus.d2e_instr, v.xInstr);
        checkOutput({tag, " pc"},      bus.d2e_pc, v.xPc);
        checkOutput({tag, " rd"},      32'(bus.d2e_rd_addr), 32'(v.xInstr[11:7]));
        checkOutput({tag, " rs1"},     32'(bus.d2e_rs1_addr), 32'(v.xInstr[19:15]));
        checkOutput({tag, " rs2"},     32'(bus.d2e_rs2_addr), 32'(v.xInstr[24:20]));
        checkOutput({tag, " opcode"},  32'(bus.d2e_opcode), 32'(v.xInstr[6:2]));
        checkOutput({tag, " illegal"}, 32'(bus.d2e_illegal_instr), 32'(v.xIllegal));
        checkOutput({tag, " exc"},     32'(bus.d2e_instr_fetch_exception), 32'(v.xExc));
        checkOutput({tag, " cause"},   bus.d2e_instr_fetch_exception_cause, v.xCause);
        checkOutput({tag, " irq"},     32'(bus.d2e_interrupt_pending), 32'(v.xIrq));
        checkOutput({tag, " imm"},     bus.d2e_imm, expImm);
    endtask

    // Build the vector table, run the reset sequence, then sweep the table.
    initial begin
        vec_t rstVec;
        checkCount = 0;
        passCount  = 0;

        //          rst   fv    instr          pc          exc   cause  irq   er    ecmd                 jt            rdy   cmd                  valid xinstr        xpc         ill   xexc  xcause xirq  ximm
        vecs[0]  = '{1'b1, 1'b1, 32'h00500093, 32'h2000, 1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b1, 32'h00500093, 32'h2000, 1'b0, 1'b0, 32'd0, 1'b0, 32'd5};
        vecs[1]  = '{1'b1, 1'b1, 32'h00108113, 32'h2004, 1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b1, 32'h00108113, 32'h2004, 1'b0, 1'b0, 32'd0, 1'b0, 32'd1};
        vecs[2]  = '{1'b1, 1'b1, 32'h00208193, 32'h2008, 1'b0, 32'd0, 1'b0, 1'b0, E2F_CMD_FLUSH,       32'h1234,     1'b0, E2F_CMD_NONE,        1'b1, 32'h00108113, 32'h2004, 1'b0, 1'b0, 32'd0, 1'b0, 32'd1};
        vecs[3]  = '{1'b1, 1'b1, 32'h00208193, 32'h2008, 1'b0, 32'd0, 1'b0, 1'b0, E2F_CMD_FLUSH,       32'h1234,     1'b0, E2F_CMD_NONE,        1'b1, 32'h00108113, 32'h2004, 1'b0, 1'b0, 32'd0, 1'b0, 32'd1};
        vecs[4]  = '{1'b1, 1'b1, 32'h00208193, 32'h2008, 1'b0, 32'd0, 1'b0, 1'b0, E2F_CMD_FLUSH,       32'h1234,     1'b0, E2F_CMD_NONE,        1'b1, 32'h00108113, 32'h2004, 1'b0, 1'b0, 32'd0, 1'b0, 32'd1};
        vecs[5]  = '{1'b1, 1'b1, 32'h00208193, 32'h2008, 1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b1, 32'h00208193, 32'h2008, 1'b0, 1'b0, 32'd0, 1'b0, 32'd2};
        vecs[6]  = '{1'b1, 1'b1, 32'h00400213, 32'h200c, 1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_BRANCHTAKEN, 32'h3000,     1'b1, E2F_CMD_BRANCHTAKEN, 1'b0, 32'h00208193, 32'h2008, 1'b0, 1'b0, 32'd0, 1'b0, 32'd2};
        vecs[7]  = '{1'b1, 1'b0, 32'h00000000, 32'h0,    1'b0, 32'd0, 1'b0, 1'b0, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b0, 32'h00208193, 32'h2008, 1'b0, 1'b0, 32'd0, 1'b0, 32'd2};
        vecs[8]  = '{1'b1, 1'b0, 32'h00000000, 32'h2010, 1'b1, 32'd1, 1'b0, 1'b0, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b1, 32'h00000000, 32'h2010, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
        vecs[9]  = '{1'b1, 1'b1, 32'h00500093, 32'h2014, 1'b0, 32'd0, 1'b0, 1'b0, E2F_CMD_NONE,        32'h0,        1'b0, E2F_CMD_NONE,        1'b1, 32'h00000000, 32'h2010, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
        vecs[10] = '{1'b1, 1'b1, 32'h00000013, 32'h4000, 1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_BUBBLE_JUMP, 32'h4000,     1'b0, E2F_CMD_BUBBLE_JUMP, 1'b0, 32'h00000000, 32'h2010, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
        vecs[11] = '{1'b1, 1'b0, 32'h00000000, 32'h0,    1'b0, 32'd0, 1'b0, 1'b0, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b0, 32'h00000000, 32'h2010, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
        vecs[12] = '{1'b1, 1'b0, 32'h00000000, 32'h5000, 1'b0, 32'd0, 1'b1, 1'b0, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b1, 32'h00000000, 32'h5000, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
        vecs[13] = '{1'b1, 1'b0, 32'h00000000, 32'h0,    1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_FLUSH,       32'h5100,     1'b0, E2F_CMD_FLUSH,       1'b0, 32'h00000000, 32'h5000, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
        vecs[14] = '{1'b1, 1'b1, 32'h00500093, 32'h5004, 1'b0, 32'd0, 1'b0, 1'b0, E2F_CMD_NONE,        32'h0,        1'b0, E2F_CMD_NONE,        1'b0, 32'h00000000, 32'h5000, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
        vecs[15] = '{1'b1, 1'b0, 32'h00000000, 32'h0,    1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_BUBBLE_JUMP, 32'h5200,     1'b0, E2F_CMD_NONE,        1'b0, 32'h00000000, 32'h5000, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
        vecs[16] = '{1'b0, 1'b1, 32'h00500093, 32'h5008, 1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_NONE,        32'h0,        1'b0, E2F_CMD_NONE,        1'b0, 32'h00000000, 32'h0,    1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[17] = '{1'b1, 1'b1, 32'h00000000, 32'h6000, 1'b0, 32'd0, 1'b0, 1'b0, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b1, 32'h00000000, 32'h6000, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[18] = '{1'b1, 1'b1, 32'h0000007f, 32'h6004, 1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b1, 32'h0000007f, 32'h6004, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
        vecs[19] = '{1'b1, 1'b0, 32'h0000007f, 32'h7000, 1'b1, 32'd7, 1'b1, 1'b1, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b1, 32'h0000007f, 32'h7000, 1'b0, 1'b1, 32'd7, 1'b1, 32'd0};
        vecs[20] = '{1'b1, 1'b0, 32'h00000000, 32'h0,    1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_BUBBLE_JUMP, 32'h8000,     1'b0, E2F_CMD_BUBBLE_JUMP, 1'b0, 32'h0000007f, 32'h7000, 1'b0, 1'b1, 32'd7, 1'b1, 32'd0};
        vecs[21] = '{1'b1, 1'b1, 32'h00500093, 32'h8000, 1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_NONE,        32'h0,        1'b1, E2F_CMD_NONE,        1'b1, 32'h00500093, 32'h8000, 1'b0, 1'b0, 32'd0, 1'b0, 32'd5};

        // Hand-written reset sequence: two cycles of reset while fetch offers work.
        rstVec = '{1'b0, 1'b1, 32'h00500093, 32'h1000, 1'b0, 32'd0, 1'b0, 1'b1, E2F_CMD_NONE, 32'h0,
                   1'b1, E2F_CMD_NONE, 1'b0, 32'h00000000, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0};
        applyStimulus(rstVec);
        repeat (2) @(posedge clk);
        #1;
        checkRegistered("reset", rstVec);
        checkOutput("reset d2f_cmd", 32'(bus.d2f_cmd), 32'(E2F_CMD_NONE));

        rst_n               = 1'b1;
        bus.f2d_instr_valid = 1'b0;
        bus.e2d_ready       = 1'b0;
        #1;
        checkOutput("post-reset d2f_ready", 32'(bus.d2f_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("post-reset valid", 32'(bus.d2e_instr_valid), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
            #2;
            checkOutput({tag, " d2f_ready"},       32'(bus.d2f_ready), 32'(vecs[i].xReady));
            checkOutput({tag, " d2f_cmd"},         32'(bus.d2f_cmd), 32'(vecs[i].xCmd));
            checkOutput({tag, " d2f_jump_target"}, bus.d2f_jump_target, vecs[i].jt);
            @(posedge clk);
            #1;
            checkRegistered(tag, vecs[i]);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
